// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction fields and ALU/memory status going into the
// controller, and datapath steering and strobes coming back out.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       mem_ready;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       ovf_exc;
    logic [3:0] state;

    // Controller side
    modport slave (
        input  opcode, funct, zero, overflow, mem_ready,
        output alu_control, alu_src_a, alu_src_b, pc_src, mem_req, mem_write,
               iord, ir_write, pc_en, reg_write, reg_dst, mem_to_reg,
               illegal, ovf_exc, state
    );

    // Datapath / environment side
    modport master (
        output opcode, funct, zero, overflow, mem_ready,
        input  alu_control, alu_src_a, alu_src_b, pc_src, mem_req, mem_write,
               iord, ir_write, pc_en, reg_write, reg_dst, mem_to_reg,
               illegal, ovf_exc, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM (with Mealy handshake
// strobes in FETCH and the branch PC enable) driving a shared-ALU datapath.
module multicycle_control (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.slave   bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Returns {supported, alu_control} for an R-type funct field.
    function automatic logic [3:0] funct_decode(input logic [5:0] f);
        case (f)
            FN_ADD:  funct_decode = 4'b1_010;
            FN_SUB:  funct_decode = 4'b1_110;
            FN_AND:  funct_decode = 4'b1_000;
            FN_OR:   funct_decode = 4'b1_001;
            FN_SLT:  funct_decode = 4'b1_111;
            default: funct_decode = 4'b0_000;
        endcase
    endfunction

    logic [3:0] state_q, state_d;
    logic [5:0] funct_q, funct_d;
    logic       is_sw_q, is_sw_d;
    logic       ovf_q,   ovf_d;
    logic [3:0] live_fn;
    logic [3:0] held_fn;
    logic       op_legal;

    assign live_fn   = funct_decode(bus.funct);
    assign held_fn   = funct_decode(funct_q);
    assign bus.state = state_q;

    // Legality of the instruction currently on the opcode/funct inputs
    always_comb begin
        op_legal = 1'b0;
        case (bus.opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            OP_RTYPE:                            op_legal = live_fn[3];
            default:                             op_legal = 1'b0;
        endcase
    end

    // Next-state logic; instruction fields are captured only in DECODE
    always_comb begin
        state_d = S_FETCH;
        funct_d = funct_q;
        is_sw_d = is_sw_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                funct_d = bus.funct;
                is_sw_d = (bus.opcode == OP_SW);
                if (!op_legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC: begin
                // Only add/sub can raise an overflow exception
                ovf_d   = bus.overflow && ((funct_q == FN_ADD) || (funct_q == FN_SUB));
                state_d = S_ALUWB;
            end
            S_ADDIEX: begin
                ovf_d   = bus.overflow;
                state_d = S_ADDIWB;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // State and captured-instruction registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            funct_q <= 6'd0;
            is_sw_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            is_sw_q <= is_sw_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output decode; everything is gated low while reset is held
    always_comb begin
        bus.alu_control = 3'b000;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.pc_src      = 2'b00;
        bus.mem_req     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_en       = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.illegal     = 1'b0;
        bus.ovf_exc     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req     = 1'b1;
                    bus.alu_src_b   = 2'b01;
                    bus.alu_control = 3'b010;
                    bus.ir_write    = bus.mem_ready;
                    bus.pc_en       = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b   = 2'b11;
                    bus.alu_control = 3'b010;
                    bus.illegal     = !op_legal;
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_src_b   = 2'b10;
                    bus.alu_control = 3'b010;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req   = 1'b1;
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_control = held_fn[2:0];
                end
                S_ALUWB: begin
                    bus.reg_write = !ovf_q;
                    bus.reg_dst   = 1'b1;
                    bus.ovf_exc   = ovf_q;
                end
                S_ADDIWB: begin
                    bus.reg_write = !ovf_q;
                    bus.ovf_exc   = ovf_q;
                end
                S_BRANCH: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_control = 3'b110;
                    bus.pc_src      = 2'b01;
                    bus.pc_en       = bus.zero;
                end
                S_JUMP: begin
                    bus.pc_src = 2'b10;
                    bus.pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port opcode, input, 6, instruction bits [31:26]; sampled only in DECODE.
REQ-004 SHALL have port funct, input, 6, instruction bits [5:0]; sampled only in DECODE.
REQ-005 SHALL have port zero, input, 1, the ALU Zero flag.
REQ-006 SHALL have port overflow, input, 1, the ALU Overflow flag.
REQ-007 SHALL have port mem_ready, input, 1, memory handshake completion.
REQ-008 SHALL have port alu_control, output, 3; bit2 = Binvert, [1:0] = operation; 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-009 SHALL have these outputs: alu_src_a (1), alu_src_b (2), pc_src (2), mem_req (1), mem_write (1), iord (1), ir_write (1), pc_en (1), reg_write (1), reg_dst (1), mem_to_reg (1), illegal (1), ovf_exc (1), state (4, debug).

Function
REQ-010 SHALL implement a Moore FSM with these state encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-011 SHALL drive outputs in FETCH as: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00; ir_write and pc_en asserted only in the cycle mem_ready=1.
REQ-012 SHALL hold FETCH while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-013 SHALL drive in DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target precompute).
REQ-014 SHALL decode as follows: opcode 100011/101011 to MEMADR, 000000 to EXEC, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP.
REQ-015 SHALL, for any other opcode, or opcode 000000 with funct not in {100000, 100010, 100100, 100101, 101010}, pulse illegal=1 in DECODE and return to FETCH with no write strobes.
REQ-016 SHALL drive in MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010; next state MEMRD for lw, MEMWR for sw.
REQ-017 SHALL drive mem_req=1, iord=1 in MEMRD/MEMWR, with mem_write=1 in MEMWR; each holds until mem_ready=1.
REQ-018 SHALL exit MEMRD to MEMWB and MEMWR to FETCH on mem_ready=1.
REQ-019 SHALL drive in MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-020 SHALL drive in EXEC: alu_src_a=1, alu_src_b=00, alu_control mapped from funct: 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111.
REQ-021 SHALL drive in ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-022 SHALL drive in ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010.
REQ-023 SHALL drive in ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-024 SHALL latch overflow into ovf_q at the end of EXEC/ADDIEX for add/sub/addi only (cleared for and/or/slt).
REQ-025 SHALL, in ALUWB/ADDIWB with ovf_q=1, force reg_write=0 and pulse ovf_exc=1 for one cycle.
REQ-026 SHALL drive in BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero (Mealy on zero only); next state FETCH.
REQ-027 SHALL drive in JUMP: pc_src=10, pc_en=1; next state FETCH.
REQ-028 SHALL drive every output not listed for a state to 0.
REQ-029 SHALL, with zero-wait memory, achieve these cycle counts from FETCH entry: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2.
REQ-030 SHALL add exactly one cycle per cycle of mem_ready=0 in FETCH, MEMRD or MEMWR.
REQ-031 SHALL ignore mem_ready in all other states.
REQ-032 SHALL decode unused state encodings 12-15 to FETCH on the next edge with all outputs 0.

Reset
REQ-033 SHALL, while rst_n=0, force state=FETCH and ovf_q=0 asynchronously, with all outputs gated to 0 (including mem_req and alu_control=000).
REQ-034 SHALL, after rst_n rises, present FETCH outputs starting in the first clk cycle.
REQ-035 SHALL, on reset assertion mid-instruction (e.g. during MEMWR wait), abort immediately with no write strobe and no further handshake.

Verification
REQ-036 SHALL cover: add (opcode 000000, funct 100000), mem_ready=1 always -> states 0,1,6,7,0; alu_control=010 in state 6; reg_write=1 and reg_dst=1 in state 7.
REQ-037 SHALL cover: lw with mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; mem_req=1 and iord=1 for all three MEMRD cycles; reg_write=1 with mem_to_reg=1.
REQ-038 SHALL cover: beq with zero=1 -> pc_en=1, pc_src=01 in state 8; repeated with zero=0 -> pc_en=0.
REQ-039 SHALL cover: addi with overflow=1 in ADDIEX -> state 10 shows reg_write=0, ovf_exc=1 for one cycle; next instruction's ovf_exc=0.
REQ-040 SHALL cover: opcode 111111, or R-type funct 000000 -> illegal=1 in DECODE, next state FETCH, no reg_write/mem_write.
REQ-041 SHALL cover: rst_n=0 asserted mid-MEMWR with mem_ready=0 -> all outputs 0 that cycle; after release state=0, mem_req=1.
